acc_bank: RTL

//  Parametrised successor to the single accumulator register in the accumulator-based CPU datapath.

---
 rtl/acc_pkg.sv | 29 ++
 rtl/acc_lifo.sv | 49 ++++
 rtl/acc_bank.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared op codes and flag layout for the accumulator bank.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package acc_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_PUSH = 3'b101;
    localparam logic [2:0] OP_POP  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int NFLAGS = 4;

    // Field order matches the FLAG_* bit indices above.
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/acc_lifo.sv
// LIFO shadow stack holding saved accumulator values.
// Latency: push/pop take effect at the clock edge; top_dat is a combinational read.
// Backpressure: none; callers must not push when full or pop when empty (requests are ignored).
module acc_lifo #(
    parameter int NBITS_D     = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic               core_clk,
    input  logic               arst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [NBITS_D-1:0] push_dat,
    output logic [NBITS_D-1:0] top_dat,
    output logic               full,
    output logic               empty
);

    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [NBITS_D-1:0] mem [STACK_DEPTH];
    logic [PW-1:0]      ptr;
    logic [AW-1:0]      wr_idx;
    logic [AW-1:0]      top_idx;

    assign full    = (ptr == PW'(STACK_DEPTH));
    assign empty   = (ptr == '0);
    assign wr_idx  = AW'(ptr);
    assign top_idx = AW'(ptr - PW'(1));
    assign top_dat = mem[top_idx];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + PW'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - PW'(1);
        end
    end

    // Storage needs no reset: the pointer alone defines which entries are live.
    always_ff @(posedge core_clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_dat;
        end
    end

endmodule

// File: rtl/acc_bank.sv
// Bank of N_ACC accumulators with registered Z/N/C/V flags and a shared LIFO shadow stack.
// Latency: one op per cycle; writes/flags/err visible the cycle after the op, o_acc reads combinationally.
// Backpressure: none; PUSH when full, POP when empty, illegal op or bad select pulse o_err and are dropped.
module acc_bank
    import acc_pkg::*;
#(
    parameter int NBITS_D     = 16,
    parameter int N_ACC       = 4,
    parameter int STACK_DEPTH = 4,
    parameter int SATURATE    = 0
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic [$clog2(N_ACC)-1:0] i_sel,
    input  logic [2:0]               i_op,
    input  logic [NBITS_D-1:0]       i_data,
    output logic [NBITS_D-1:0]       o_acc,
    output logic                     o_zero,
    output logic                     o_neg,
    output logic                     o_carry,
    output logic                     o_ovf,
    output logic                     o_stack_full,
    output logic                     o_stack_empty,
    output logic                     o_err
);

    localparam int MSB = NBITS_D - 1;
    localparam logic [NBITS_D-1:0] SAT_MAX = {1'b0, {(NBITS_D-1){1'b1}}};
    localparam logic [NBITS_D-1:0] SAT_MIN = {1'b1, {(NBITS_D-1){1'b0}}};

    logic [1:0]         rst_sync;
    logic               arst_n;
    logic [NBITS_D-1:0] acc_q [N_ACC];
    flags_t             flags_q;
    logic               err_q;

    logic               sel_ok;
    logic [NBITS_D-1:0] cur;
    logic [NBITS_D:0]   sum_ext;
    logic [NBITS_D:0]   diff_ext;
    logic               add_ovf;
    logic               sub_ovf;
    logic [NBITS_D-1:0] add_res;
    logic [NBITS_D-1:0] sub_res;

    logic               wr_en;
    logic [NBITS_D-1:0] wr_dat;
    logic               upd_zn;
    logic               upd_cv;
    logic               c_new;
    logic               v_new;
    logic               push;
    logic               pop;
    logic               err_d;

    logic [NBITS_D-1:0] top_dat;
    logic               full;
    logic               empty;

    // Reset asserts asynchronously but releases only on a clock edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign arst_n = rst_sync[1];

    assign sel_ok = (int'(i_sel) < N_ACC);
    assign cur    = sel_ok ? acc_q[i_sel] : '0;
    assign o_acc  = cur;

    assign sum_ext  = {1'b0, cur} + {1'b0, i_data};
    assign diff_ext = {1'b0, cur} - {1'b0, i_data};
    assign add_ovf  = (cur[MSB] == i_data[MSB]) && (sum_ext[MSB] != cur[MSB]);
    assign sub_ovf  = (cur[MSB] != i_data[MSB]) && (diff_ext[MSB] != cur[MSB]);

    // Overflow direction always follows the sign of the original accumulator.
    always_comb begin
        add_res = sum_ext[NBITS_D-1:0];
        sub_res = diff_ext[NBITS_D-1:0];
        if (SATURATE != 0 && add_ovf) begin
            add_res = cur[MSB] ? SAT_MIN : SAT_MAX;
        end
        if (SATURATE != 0 && sub_ovf) begin
            sub_res = cur[MSB] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_dat = cur;
        upd_zn = 1'b0;
        upd_cv = 1'b0;
        c_new  = flags_q.c;
        v_new  = flags_q.v;
        push   = 1'b0;
        pop    = 1'b0;
        err_d  = 1'b0;
        case (i_op)
            OP_LOAD: begin
                wr_en  = 1'b1;
                wr_dat = i_data;
                upd_zn = 1'b1;
            end
            OP_ADD: begin
                wr_en  = 1'b1;
                wr_dat = add_res;
                upd_zn = 1'b1;
                upd_cv = 1'b1;
                c_new  = sum_ext[NBITS_D];
                v_new  = add_ovf;
            end
            OP_SUB: begin
                wr_en  = 1'b1;
                wr_dat = sub_res;
                upd_zn = 1'b1;
                upd_cv = 1'b1;
                c_new  = diff_ext[NBITS_D];
                v_new  = sub_ovf;
            end
            OP_CLR: begin
                wr_en  = 1'b1;
                wr_dat = '0;
                upd_zn = 1'b1;
            end
            OP_PUSH: begin
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            OP_POP: begin
                if (empty) begin
                    err_d = 1'b1;
                end else begin
                    pop    = 1'b1;
                    wr_en  = 1'b1;
                    wr_dat = top_dat;
                    upd_zn = 1'b1;
                end
            end
            OP_ILL: begin
                err_d = 1'b1;
            end
            default: begin
            end
        endcase
        if (!sel_ok) begin
            wr_en  = 1'b0;
            upd_zn = 1'b0;
            upd_cv = 1'b0;
            push   = 1'b0;
            pop    = 1'b0;
            err_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < N_ACC; i++) begin
                acc_q[i] <= '0;
            end
        end else if (wr_en) begin
            acc_q[i_sel] <= wr_dat;
        end
    end

    always_ff @(posedge i_clock or negedge arst_n) begin
        if (!arst_n) begin
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            if (upd_zn) begin
                flags_q.z <= (wr_dat == '0);
                flags_q.n <= wr_dat[MSB];
            end
            if (upd_cv) begin
                flags_q.c <= c_new;
                flags_q.v <= v_new;
            end
        end
    end

    acc_lifo #(
        .NBITS_D     (NBITS_D),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_lifo (
        .core_clk (i_clock),
        .arst_n   (arst_n),
        .push     (push),
        .pop      (pop),
        .push_dat (cur),
        .top_dat  (top_dat),
        .full     (full),
        .empty    (empty)
    );

    assign o_zero        = flags_q.z;
    assign o_neg         = flags_q.n;
    assign o_carry       = flags_q.c;
    assign o_ovf         = flags_q.v;
    assign o_stack_full  = full;
    assign o_stack_empty = empty;
    assign o_err         = err_q;

endmodule
